// File: rtl/aq_vpu_viq0_ex_pipe_pkg.sv
// Shared definitions for the VIQ0 execute pipeline: field widths and the
// control-payload bit layout {eu_sel, func, gp_sel, rm} (37 bits at the
// default group-select width).
package aq_vpu_viq0_ex_pipe_pkg;

  localparam int EU_WIDTH     = 10;
  localparam int FUNC_WIDTH   = 20;
  localparam int GP_WIDTH_DEF = 4;
  localparam int RM_WIDTH     = 3;
  localparam int ID_WIDTH     = 2;

  // gp_sel sits directly above rm in the packed control word.
  localparam int GP_LSB       = RM_WIDTH;

  // Width of the packed control word for a given group-select width.
  function automatic int ctrl_width(input int gp_w);
    return EU_WIDTH + FUNC_WIDTH + gp_w + RM_WIDTH;
  endfunction

endpackage

// File: rtl/aq_vpu_viq0_ex_pipe_stage_reg.sv
// One execute stage: valid bit plus control payload with load/hold/flush.
// The payload loads whenever the stage is not held; the valid bit is cleared
// by flush. gp_sel is forced to zero on the output while the stage is empty.
module aq_vpu_ex_stage_reg
  import aq_vpu_viq0_ex_pipe_pkg::*;
#(
  parameter int GP_WIDTH = GP_WIDTH_DEF,
  parameter int CTRL_W   = ctrl_width(GP_WIDTH_DEF)
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              flush,
  input  logic              hold,
  input  logic              vld_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              vld,
  output logic [CTRL_W-1:0] ctrl_out
);

  logic [CTRL_W-1:0] ctrl_q;

  // Stage valid: flush wins, a held stage keeps its op, otherwise take upstream.
  // NOTE: sequential state uses non-blocking (<=) so every stage samples the
  // pre-edge value of its neighbour; blocking here would shift ops through
  // several stages in one clock.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vld <= 1'b0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (!hold) begin
      vld <= vld_in;
    end
  end

  // Payload register: loads on every non-held cycle, untouched by flush.
  // NOTE: the payload is a plain register, not a memory, so it is reset to
  // zero; that is what makes every output read 0 straight out of reset.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ctrl_q <= '0;
    end else if (!hold) begin
      ctrl_q <= ctrl_in;
    end
  end

  // Output view: group select gated off while the stage is empty.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    ctrl_out = ctrl_q;
    if (!vld) ctrl_out[GP_LSB +: GP_WIDTH] = '0;
  end

endmodule

// File: rtl/aq_vpu_viq0_ex_pipe.sv
// VIQ0 execute pipeline control: carries issued vector ops through EX1..EX4
// with per-stage valid, backward stall (EX2 iterative unit, EX4 writeback
// conflict) and flush. EX1 additionally carries operands and the id tag.
// Optional build macro VPU_EX_BUBBLE_COLLAPSE_EN: hold only propagates
// upstream through occupied stages, so ops advance into a bubble ahead of a
// stalled stage. Without it every stage upstream of a stall holds.
module aq_vpu_viq0_ex_pipe
  import aq_vpu_viq0_ex_pipe_pkg::*;
#(
  parameter int GP_WIDTH = GP_WIDTH_DEF,
  parameter int FLEN     = 64,
  parameter int TYPE_W   = 48
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  idu_vpu_issue_vld,
  input  logic [EU_WIDTH-1:0]   idu_vpu_issue_eu_sel,
  input  logic [FUNC_WIDTH-1:0] idu_vpu_issue_func,
  input  logic [GP_WIDTH-1:0]   idu_vpu_issue_gp_sel,
  input  logic [RM_WIDTH-1:0]   idu_vpu_issue_rm,
  input  logic [ID_WIDTH-1:0]   idu_vpu_issue_id_reg,
  input  logic [FLEN-1:0]       idu_vpu_issue_srcv0,
  input  logic [FLEN-1:0]       idu_vpu_issue_srcv1,
  input  logic [FLEN-1:0]       idu_vpu_issue_srcv2,
  input  logic [TYPE_W-1:0]     idu_vpu_issue_srcv0_type,
  input  logic [TYPE_W-1:0]     idu_vpu_issue_srcv1_type,
  input  logic [TYPE_W-1:0]     idu_vpu_issue_srcv2_type,
  output logic                  vpu_idu_issue_rdy,
  input  logic                  rtu_vpu_flush,
  input  logic                  vpu_ex2_stall_req,
  input  logic                  vpu_ex4_stall_req,
  output logic [EU_WIDTH-1:0]   viq0_xx_ex1_eu_sel,
  output logic [FUNC_WIDTH-1:0] viq0_xx_ex1_func,
  output logic [GP_WIDTH-1:0]   viq0_xx_ex1_gp_sel,
  output logic [RM_WIDTH-1:0]   viq0_xx_ex1_rm,
  output logic [ID_WIDTH-1:0]   viq0_xx_ex1_id_reg,
  output logic [FLEN-1:0]       viq0_xx_ex1_srcv0,
  output logic [FLEN-1:0]       viq0_xx_ex1_srcv1,
  output logic [FLEN-1:0]       viq0_xx_ex1_srcv2,
  output logic [TYPE_W-1:0]     viq0_xx_ex1_srcv0_type,
  output logic [TYPE_W-1:0]     viq0_xx_ex1_srcv1_type,
  output logic [TYPE_W-1:0]     viq0_xx_ex1_srcv2_type,
  output logic [EU_WIDTH-1:0]   viq0_xx_ex2_eu_sel,
  output logic [FUNC_WIDTH-1:0] viq0_xx_ex2_func,
  output logic [GP_WIDTH-1:0]   viq0_xx_ex2_gp_sel,
  output logic [RM_WIDTH-1:0]   viq0_xx_ex2_rm,
  output logic                  viq0_xx_ex2_stall,
  output logic [EU_WIDTH-1:0]   viq0_xx_ex3_eu_sel,
  output logic [FUNC_WIDTH-1:0] viq0_xx_ex3_func,
  output logic [GP_WIDTH-1:0]   viq0_xx_ex3_gp_sel,
  output logic [RM_WIDTH-1:0]   viq0_xx_ex3_rm,
  output logic                  viq0_xx_ex3_stall,
  output logic [EU_WIDTH-1:0]   viq0_xx_ex4_eu_sel,
  output logic [FUNC_WIDTH-1:0] viq0_xx_ex4_func,
  output logic [GP_WIDTH-1:0]   viq0_xx_ex4_gp_sel,
  output logic [RM_WIDTH-1:0]   viq0_xx_ex4_rm,
  output logic                  viq0_xx_ex4_stall
);

  localparam int CTRL_W = ctrl_width(GP_WIDTH);

  logic              h1, h2, h3, h4;
  logic              issue_fire;
  logic              ex1_vld, ex2_vld, ex3_vld, ex4_vld;
  logic [CTRL_W-1:0] ex1_ctrl_q, ex1_ctrl, ex2_ctrl, ex3_ctrl, ex4_ctrl;

  // Hold terms: a stage holds when it or any stage it feeds is stuck.
  always_comb begin
    h4 = ex4_vld & vpu_ex4_stall_req;
`ifdef VPU_EX_BUBBLE_COLLAPSE_EN
    h3 = h4 & ex3_vld;
    h2 = (ex2_vld & vpu_ex2_stall_req) | (h3 & ex2_vld);
    h1 = h2 & ex1_vld;
`else
    h3 = h4;
    h2 = (ex2_vld & vpu_ex2_stall_req) | h3;
    h1 = h2;
`endif
  end

  assign vpu_idu_issue_rdy = ~h1;
  assign issue_fire        = idu_vpu_issue_vld & vpu_idu_issue_rdy;

  // EX1 valid: flush kills, hold keeps, otherwise take the accepted issue.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ex1_vld <= 1'b0;
    end else if (rtu_vpu_flush) begin
      ex1_vld <= 1'b0;
    end else if (!h1) begin
      ex1_vld <= idu_vpu_issue_vld;
    end
  end

  // EX1 payload and operands: load only on an accepted issue.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ex1_ctrl_q             <= '0;
      viq0_xx_ex1_id_reg     <= '0;
      viq0_xx_ex1_srcv0      <= '0;
      viq0_xx_ex1_srcv1      <= '0;
      viq0_xx_ex1_srcv2      <= '0;
      viq0_xx_ex1_srcv0_type <= '0;
      viq0_xx_ex1_srcv1_type <= '0;
      viq0_xx_ex1_srcv2_type <= '0;
    end else if (issue_fire) begin
      ex1_ctrl_q             <= {idu_vpu_issue_eu_sel, idu_vpu_issue_func,
                                 idu_vpu_issue_gp_sel, idu_vpu_issue_rm};
      viq0_xx_ex1_id_reg     <= idu_vpu_issue_id_reg;
      viq0_xx_ex1_srcv0      <= idu_vpu_issue_srcv0;
      viq0_xx_ex1_srcv1      <= idu_vpu_issue_srcv1;
      viq0_xx_ex1_srcv2      <= idu_vpu_issue_srcv2;
      viq0_xx_ex1_srcv0_type <= idu_vpu_issue_srcv0_type;
      viq0_xx_ex1_srcv1_type <= idu_vpu_issue_srcv1_type;
      viq0_xx_ex1_srcv2_type <= idu_vpu_issue_srcv2_type;
    end
  end

  // EX1 output view with group select gated while empty.
  always_comb begin
    ex1_ctrl = ex1_ctrl_q;
    if (!ex1_vld) ex1_ctrl[GP_LSB +: GP_WIDTH] = '0;
  end

  aq_vpu_ex_stage_reg #(.GP_WIDTH(GP_WIDTH), .CTRL_W(CTRL_W)) u_ex2 (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .flush          (rtu_vpu_flush),
    .hold           (h2),
    .vld_in         (ex1_vld & ~h1),
    .ctrl_in        (ex1_ctrl),
    .vld            (ex2_vld),
    .ctrl_out       (ex2_ctrl)
  );

  aq_vpu_ex_stage_reg #(.GP_WIDTH(GP_WIDTH), .CTRL_W(CTRL_W)) u_ex3 (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .flush          (rtu_vpu_flush),
    .hold           (h3),
    .vld_in         (ex2_vld & ~h2),
    .ctrl_in        (ex2_ctrl),
    .vld            (ex3_vld),
    .ctrl_out       (ex3_ctrl)
  );

  aq_vpu_ex_stage_reg #(.GP_WIDTH(GP_WIDTH), .CTRL_W(CTRL_W)) u_ex4 (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .flush          (rtu_vpu_flush),
    .hold           (h4),
    .vld_in         (ex3_vld & ~h3),
    .ctrl_in        (ex3_ctrl),
    .vld            (ex4_vld),
    .ctrl_out       (ex4_ctrl)
  );

  assign {viq0_xx_ex1_eu_sel, viq0_xx_ex1_func, viq0_xx_ex1_gp_sel, viq0_xx_ex1_rm} = ex1_ctrl;
  assign {viq0_xx_ex2_eu_sel, viq0_xx_ex2_func, viq0_xx_ex2_gp_sel, viq0_xx_ex2_rm} = ex2_ctrl;
  assign {viq0_xx_ex3_eu_sel, viq0_xx_ex3_func, viq0_xx_ex3_gp_sel, viq0_xx_ex3_rm} = ex3_ctrl;
  assign {viq0_xx_ex4_eu_sel, viq0_xx_ex4_func, viq0_xx_ex4_gp_sel, viq0_xx_ex4_rm} = ex4_ctrl;

  assign viq0_xx_ex2_stall = h2;
  assign viq0_xx_ex3_stall = h3;
  assign viq0_xx_ex4_stall = h4;

endmodule
